// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_pkg
// Description : Shared state encoding and default word width for the bit
//               serializer and its holding-register sub-module.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_serializer_hold.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_hold
// Description : One-entry holding register with a full flag. Captures the
//               next word while the shifter is busy; drained by the shifter
//               on its last bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // Write sets the entry full; a drain only clears the flag. The two never
    // coincide because writes are only accepted while the entry is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial converter with valid/ready load handshake,
//               one-word look-ahead buffer and gapless back-to-back output.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_adv;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cur_bit;
    logic             w_xfer;
    logic             w_last;
    logic             w_hold_wr;
    logic             w_hold_rd;
    logic             w_hold_full;
    logic [WIDTH-1:0] w_hold_data;

    // The current bit always sits at the outgoing end of the shifter, so the
    // counter is only needed to find the word boundary.
    if (MSB_FIRST) begin : g_msb_first
        assign w_cur_bit   = r_shift[WIDTH-1];
        assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_cur_bit   = r_shift[0];
        assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end

    assign load_ready = !w_hold_full && !rst;
    assign w_xfer     = load_valid && load_ready;
    assign w_last     = (r_state == SHIFT) && (r_cnt == C_LAST);

    bit_serializer_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_wr   (w_hold_wr),
        .i_rd   (w_hold_rd),
        .i_data (data_in),
        .o_data (w_hold_data),
        .o_full (w_hold_full)
    );

    // Next-state logic: load from idle, shift each cycle, and at the word
    // boundary pick held word, then bypass word, else fall back to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_hold_wr   = 1'b0;
        w_hold_rd   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = data_in;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                w_shift_nxt = w_shift_adv;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (w_hold_full) begin
                        w_shift_nxt = w_hold_data;
                        w_hold_rd   = 1'b1;
                    end else if (w_xfer) begin
                        w_shift_nxt = data_in;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer) begin
                    w_hold_wr = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, shifter and bit counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // dout is forced low outside payload cycles so a downstream detector
    // only ever sees zeros while idle.
    assign dout_valid = (r_state == SHIFT);
    assign dout       = dout_valid && w_cur_bit;
    assign busy       = (r_state == SHIFT) || w_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Self-checking bench for bit_serializer. Two instances (MSB
//               first and LSB first) share stimulus; a queue-of-words model
//               predicts every output each cycle, and directed tests pin the
//               model with literal bit patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready_m, dout_m, dout_valid_m, busy_m;
    logic       load_ready_l, dout_l, dout_valid_l, busy_l;

    int errors = 0;
    int checks = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_m (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready_m),
        .dout       (dout_m),
        .dout_valid (dout_valid_m),
        .busy       (busy_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_l (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready_l),
        .dout       (dout_l),
        .dout_valid (dout_valid_l),
        .busy       (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: words waiting or in flight, oldest first; mpos = bits of the
    // front word already emitted. At most two words: one shifting, one held.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    int         mpos = 0;
    bit         m_tx;
    bit         cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mpos = 0;
        end else begin
            m_tx = load_valid && (mq.size() < 2);
            if (mq.size() > 0) begin
                mpos++;
                if (mpos == 8) begin
                    void'(mq.pop_front());
                    mpos = 0;
                end
            end
            if (m_tx) mq.push_back(data_in);
        end
    end

    logic [7:0] c_word;
    logic       c_valid, c_bit_m, c_bit_l, c_ready;

    always @(negedge clk) begin
        if (cmp_en) begin
            c_valid = (mq.size() > 0);
            c_word  = c_valid ? mq[0] : 8'h00;
            c_bit_m = c_valid ? c_word[7 - mpos] : 1'b0;
            c_bit_l = c_valid ? c_word[mpos] : 1'b0;
            c_ready = !rst && (mq.size() < 2);
            check("m_dout",       {31'd0, dout_m},       {31'd0, c_bit_m});
            check("m_dout_valid", {31'd0, dout_valid_m}, {31'd0, c_valid});
            check("m_load_ready", {31'd0, load_ready_m}, {31'd0, c_ready});
            check("m_busy",       {31'd0, busy_m},       {31'd0, c_valid});
            check("l_dout",       {31'd0, dout_l},       {31'd0, c_bit_l});
            check("l_dout_valid", {31'd0, dout_valid_l}, {31'd0, c_valid});
            check("l_load_ready", {31'd0, load_ready_l}, {31'd0, c_ready});
            check("l_busy",       {31'd0, busy_l},       {31'd0, c_valid});
        end
    end

    // Behavioural 1101 overlapping Mealy detector fed by the MSB-first dout.
    logic [2:0] det_hist = 3'b000;
    logic       det_y;
    always @(posedge clk) det_hist <= {det_hist[1:0], dout_m};
    assign det_y = ({det_hist, dout_m} == 4'b1101);

    // Capture of emitted bits, first bit ends up most significant.
    logic [63:0] cap_m, cap_l;
    int          nvalid, run, maxrun, npulse;

    task automatic clr_cap();
        cap_m = '0; cap_l = '0; nvalid = 0; run = 0; maxrun = 0; npulse = 0;
    endtask

    task automatic cyc(input logic lv, input logic [7:0] d, output logic rdy);
        load_valid = lv;
        data_in    = d;
        @(negedge clk);
        rdy = load_ready_m;
        if (dout_valid_m) begin
            cap_m = {cap_m[62:0], dout_m};
            nvalid++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
        if (dout_valid_l) cap_l = {cap_l[62:0], dout_l};
        if (det_y) npulse++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic r;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic       r;
    int         k, low;
    logic [7:0] bp_w [3];

    initial begin
        bp_w[0] = 8'hA5; bp_w[1] = 8'h3C; bp_w[2] = 8'h96;
        rst = 1'b1; load_valid = 1'b0; data_in = 8'h00;
        clr_cap();
        @(posedge clk); #1;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Reset state
        @(negedge clk);
        check("rst_dout_valid", {31'd0, dout_valid_m}, 32'd0);
        check("rst_busy",       {31'd0, busy_m},       32'd0);
        check("rst_load_ready", {31'd0, load_ready_m}, 32'd0);
        check("rst_dout",       {31'd0, dout_m},       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, load_ready_m}, 32'd1);
        @(posedge clk); #1;

        // Single word 8'hDB, plus detector integration
        clr_cap();
        cyc(1'b1, 8'hDB, r);
        cyc(1'b0, 8'h00, r);
        check("first_bit_latency", nvalid, 1);
        idle(10);
        check("single_bits_m",  {24'd0, cap_m[7:0]}, 32'h0000_00DB);
        check("single_bits_l",  {24'd0, cap_l[7:0]}, 32'h0000_00DB);
        check("single_nvalid",  nvalid, 8);
        check("detector_pulses", npulse, 2);

        // Bit order pinned with 8'h01
        clr_cap();
        cyc(1'b1, 8'h01, r);
        idle(10);
        check("order_01_m", {24'd0, cap_m[7:0]}, 32'h0000_0001);
        check("order_01_l", {24'd0, cap_l[7:0]}, 32'h0000_0080);

        // Back-to-back: second word goes to the holding register
        clr_cap();
        cyc(1'b1, 8'hDB, r);
        cyc(1'b1, 8'h0F, r);
        idle(20);
        check("b2b_bits",   {16'd0, cap_m[15:0]}, 32'h0000_DB0F);
        check("b2b_nvalid", nvalid, 16);
        check("b2b_gapless", maxrun, 16);

        // Backpressure: three words offered continuously
        clr_cap();
        k = 0; low = 0;
        for (int it = 0; it < 40 && k < 3; it++) begin
            cyc(1'b1, bp_w[k], r);
            if (r) k++;
            else   low++;
        end
        check("bp_all_taken", k, 3);
        check("bp_ready_low_cycles", low, 7);
        idle(30);
        check("bp_bits",   {8'd0, cap_m[23:0]}, 32'h00A5_3C96);
        check("bp_gapless", maxrun, 24);

        // Reset mid-word with a held word
        clr_cap();
        cyc(1'b1, 8'hFF, r);
        cyc(1'b1, 8'h55, r);
        cyc(1'b0, 8'h00, r);
        cyc(1'b0, 8'h00, r);
        check("pre_rst_nvalid", nvalid, 3);
        rst = 1'b1;
        cyc(1'b0, 8'h00, r);
        rst = 1'b0;
        @(negedge clk);
        check("abort_dout_valid", {31'd0, dout_valid_m}, 32'd0);
        check("abort_busy",       {31'd0, busy_m},       32'd0);
        @(posedge clk); #1;
        clr_cap();
        idle(12);
        check("abort_no_bits", nvalid, 0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: byte width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = emit bit WIDTH-1 first, 0 = emit bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  WIDTH  parallel word offered for serialization.
REQ-006 load_valid  input  1  data_in is valid this cycle.
REQ-007 load_ready  output  1  block can accept data_in this cycle.
REQ-008 dout  output  1  serial bit stream; directly drives a downstream detector's din.
REQ-009 dout_valid  output  1  dout carries a payload bit this cycle.
REQ-010 busy  output  1  shift register or holding register is occupied.

Function
REQ-011 Transfer occurs in a cycle where load_valid and load_ready are both 1 at the rising edge; at most one transfer per cycle.
REQ-012 Storage: one shift register (WIDTH bits), one bit counter (0..WIDTH-1), and one one-entry holding register with a full flag.
REQ-013 FSM states: IDLE (nothing shifting) and SHIFT (emitting bits).
REQ-014 IDLE + transfer -> SHIFT next cycle, with the word in the shift register and counter = 0; first bit appears on dout exactly one cycle after the transfer edge.
REQ-015 In SHIFT, each cycle: dout_valid = 1, dout = current bit per MSB_FIRST, counter increments by 1.
REQ-016 Last-bit cycle (counter = WIDTH-1) next-word priority: (1) holding register if full, which is then cleared; (2) word transferred in that same cycle (bypass); (3) otherwise go to IDLE.
REQ-017 Back-to-back words produce a gapless stream: dout_valid stays 1 across word boundaries.
REQ-018 Transfer during SHIFT on a non-last-bit cycle writes the holding register and sets its full flag.
REQ-019 load_ready = !hold_full and !rst (combinational); in IDLE and in SHIFT with an empty holding register it is 1.
REQ-020 Holding register full and SHIFT on its last bit: the holding register drains into the shift register; load_ready remains 0 in that cycle and becomes 1 in the next.
REQ-021 When dout_valid = 0, dout SHALL be 0.
REQ-022 busy = (state == SHIFT) or hold_full.
REQ-023 load_valid with load_ready = 0 has no effect; data_in is ignored.

Reset
REQ-024 While rst = 1 at a rising edge: state = IDLE, counter = 0, shift and holding registers = 0, hold_full = 0.
REQ-025 Outputs during and after reset until the first transfer: dout = 0, dout_valid = 0, busy = 0, load_ready = 0 while rst = 1 and 1 after.
REQ-026 Reset asserted mid-word aborts the word and discards any held word; no partial bits are emitted after rst deasserts.

Structure
REQ-027 Shared package bit_serializer_pkg holds the state enum (IDLE, SHIFT) and default WIDTH constant.
REQ-028 Holding register plus full flag is one sub-module, bit_serializer_hold; everything else lives in bit_serializer.

Verification
REQ-029 Single word: WIDTH = 8, MSB_FIRST = 1, transfer 8'hDB -> dout = 1,1,0,1,1,0,1,1 on cycles 1..8 after transfer, dout_valid high exactly 8 cycles, then IDLE.
REQ-030 Back-to-back: transfer 8'hDB then 8'h0F, load_valid held -> 16 consecutive valid bits 11011011 00001111 with no gap; second transfer lands in the holding register.
REQ-031 Backpressure: three words offered continuously -> load_ready drops after the second transfer and rises the cycle after the first word's last bit; all 24 bits are emitted in order.
REQ-032 LSB_first: MSB_FIRST = 0, transfer 8'hDB -> dout = 1,1,0,1,1,0,1,1 reversed order (1,1,0,1,1,0,1,1 = bits 0..7 of 8'hDB); check against 8'h01 -> 1,0,0,0,0,0,0,0.
REQ-033 Reset mid-word: assert rst after bit 3 of 8'hFF with a held word -> next cycle dout_valid = 0, busy = 0; after deassert no further bits until a new transfer.
REQ-034 Integration: dout drives seq_detect_mealy din; transfer 8'hDB MSB-first -> detector y pulses exactly twice (overlapping 1101), zero pulses during idle zeros.
